// File: rtl/button_press_decoder_pkg.sv
//==============================================================================
// Module      : button_press_decoder_pkg
// Description : Shared state encodings and 5 kHz tick defaults for the
//               button press decoder and its edge-detect helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package button_press_decoder_pkg;

    // Decoder FSM states, encodings fixed so other buttons' logic can match them
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } btn_state_t;

    // Defaults for a 5 kHz clock: 1 s to long press, 200 ms repeat period
    localparam int c_DEFAULT_LONG_TICKS   = 5000;
    localparam int c_DEFAULT_REPEAT_TICKS = 1000;
    localparam int c_DEFAULT_CNT_W        = 13;

endpackage : button_press_decoder_pkg

`default_nettype wire

// File: rtl/button_press_decoder_btn_edge_detect.sv
//==============================================================================
// Module      : btn_edge_detect
// Description : Two-stage button level register with rising-edge output.
//               Both stages reset to 1 so a button held through reset is
//               not seen as a fresh press until it is released first.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module btn_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_btn_q,
    output logic o_rise
);

    logic r_btn_q;
    logic r_btn_d;

    // Level delay chain; reset-to-pressed masks a button held through reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_q <= 1'b1;
            r_btn_d <= 1'b1;
        end else begin
            r_btn_q <= i_btn;
            r_btn_d <= r_btn_q;
        end
    end

    assign o_btn_q = r_btn_q;
    assign o_rise  = r_btn_q & ~r_btn_d;

endmodule : btn_edge_detect

`default_nettype wire

// File: rtl/button_press_decoder.sv
//==============================================================================
// Module      : button_press_decoder
// Description : Turns a debounced button level into single-cycle short_press,
//               long_press and auto-repeat events plus a held level.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module button_press_decoder
    import button_press_decoder_pkg::*;
#(
    parameter int LONG_TICKS   = c_DEFAULT_LONG_TICKS,
    parameter int REPEAT_TICKS = c_DEFAULT_REPEAT_TICKS,
    parameter int CNT_W        = c_DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] c_LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE     = CNT_W'(1);

    logic             w_btn_q;
    logic             w_rise;

    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_short_nxt;
    logic             w_long_nxt;
    logic             w_rep_nxt;
    logic             w_held_nxt;

    btn_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_in),
        .o_btn_q (w_btn_q),
        .o_rise  (w_rise)
    );

    // State, hold counter and registered event outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            short_press  <= w_short_nxt;
            long_press   <= w_long_nxt;
            repeat_pulse <= w_rep_nxt;
            held         <= w_held_nxt;
        end
    end

    // Next-state, counter and pulse decode; release is checked before thresholds
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_short_nxt = 1'b0;
        w_long_nxt  = 1'b0;
        w_rep_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = PRESS;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS: begin
                if (!w_btn_q) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_LONG_LAST) begin
                    w_long_nxt  = 1'b1;
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            HOLD: begin
                // Counter runs regardless of repeat_en so the repeat phase is fixed
                if (!w_btn_q) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_REPEAT_LAST) begin
                    w_rep_nxt   = repeat_en;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_held_nxt = (w_state_nxt == PRESS) || (w_state_nxt == HOLD);
    end

endmodule : button_press_decoder

`default_nettype wire
